// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready on both sides, backed by a main + skid entry.
// in_ready comes from the skid register only, so back-pressure never forms a combinational path.
module pipe_stage_elastic #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_FIELDS = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_FIELDS*DATA_WIDTH-1:0] out_data,
  output logic [1:0]                       occupancy,
  output logic [CNT_WIDTH-1:0]             stall_cnt
);

  localparam int PW = NUM_FIELDS * DATA_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state;
  logic                   main_valid;
  logic                   skid_valid;
  logic [PW-1:0]          main_data;
  logic [PW-1:0]          skid_data;
  logic [CNT_WIDTH-1:0]   stall_q;
  logic                   push;
  logic                   pop;

  assign push      = in_valid & in_ready;
  assign pop       = main_valid & out_ready;
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : '0;
  assign occupancy = state;
  assign stall_cnt = stall_q;

  // The main entry is always the older one; the skid entry only fills while main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      stall_q    <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_q != '1))
        stall_q <= stall_q + CNT_WIDTH'(1);

      if (flush) begin
        state      <= EMPTY;
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
        main_data  <= '0;
        skid_data  <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (push) begin
              main_data  <= in_data;
              main_valid <= 1'b1;
              state      <= ONE;
            end
          end
          ONE: begin
            if (push && pop) begin
              main_data <= in_data;
            end else if (push) begin
              skid_data  <= in_data;
              skid_valid <= 1'b1;
              state      <= FULL;
            end else if (pop) begin
              main_valid <= 1'b0;
              state      <= EMPTY;
            end
          end
          FULL: begin
            if (pop) begin
              main_data  <= skid_data;
              skid_valid <= 1'b0;
              skid_data  <= '0;
              state      <= ONE;
            end
          end
          default: begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios plus randomized traffic against a queue model.
// A second instance with a 4-bit counter shares all inputs to exercise saturation.
module tb_pipe_stage_elastic;

  localparam int DW = 32;
  localparam int NF = 3;
  localparam int PW = DW * NF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [PW-1:0] in_data = '0;

  logic          in_ready, out_valid;
  logic [PW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  logic          in_ready4, out_valid4;
  logic [PW-1:0] out_data4;
  logic [1:0]    occupancy4;
  logic [3:0]    stall_cnt4;

  pipe_stage_elastic #(.DATA_WIDTH(DW), .NUM_FIELDS(NF), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_elastic #(.DATA_WIDTH(DW), .NUM_FIELDS(NF), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: a FIFO holding at most two payloads, plus stall counters
  logic [PW-1:0] q[$];
  int            cnt16 = 0;
  int            cnt4  = 0;

  wire [99:0]  hs    = {out_valid, out_data, in_ready, occupancy};
  wire [99:0]  hs4   = {out_valid4, out_data4, in_ready4, occupancy4};
  wire [119:0] actv  = {hs, stall_cnt, stall_cnt4};

  localparam logic [PW-1:0] PAY1 = {32'h0000_0104, 32'h0000_0100, 32'h0050_0093};

  function automatic logic [99:0] exp_hs();
    logic [PW-1:0] h;
    h = (q.size() > 0) ? q[0] : '0;
    return {q.size() > 0, h, q.size() < 2, 2'(q.size())};
  endfunction

  function automatic logic [119:0] exp_all();
    return {exp_hs(), 16'(cnt16), 4'(cnt4)};
  endfunction

  // Advance one clock edge, update the model from the inputs seen at that edge, then settle
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      cnt16 = 0;
      cnt4  = 0;
    end else begin
      bit acc, popd;
      if (in_valid && q.size() == 2) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt4 < 15) cnt4++;
      end
      acc  = in_valid && (q.size() < 2);
      popd = (q.size() > 0) && out_ready;
      if (flush) q.delete();
      else begin
        if (popd) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    q.delete(); cnt16 = 0; cnt4 = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_data = {$urandom, $urandom, $urandom};
    repeat (2) tick();
    vectors++;
    if (actv !== {1'b0, {PW{1'b0}}, 1'b1, 2'd0, 16'd0, 4'd0}) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %h expected %h", actv, {1'b0, {PW{1'b0}}, 1'b1, 2'd0, 16'd0, 4'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (actv !== {1'b0, {PW{1'b0}}, 1'b1, 2'd0, 16'd0, 4'd0}) begin
      errors++;
      $display("[TB] FAIL reset_release: got %h expected %h", actv, {1'b0, {PW{1'b0}}, 1'b1, 2'd0, 16'd0, 4'd0});
    end
  endtask

  task automatic test_single(input string tag);
    in_data = PAY1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (hs !== {1'b1, PAY1, 1'b1, 2'd1}) begin
      errors++;
      $display("[TB] FAIL %s_out: got %h expected %h", tag, hs, {1'b1, PAY1, 1'b1, 2'd1});
    end
    tick();
    vectors++;
    if (hs !== {1'b0, {PW{1'b0}}, 1'b1, 2'd0}) begin
      errors++;
      $display("[TB] FAIL %s_drain: got %h expected %h", tag, hs, {1'b0, {PW{1'b0}}, 1'b1, 2'd0});
    end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] d[8];
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d[i] = {$urandom, $urandom, $urandom};
      in_data = d[i]; in_valid = 1'b1;
      tick();
      vectors++;
      if ({hs, stall_cnt} !== {1'b1, d[i], 1'b1, 2'd1, 16'd0}) begin
        errors++;
        $display("[TB] FAIL stream_%0d: got %h expected %h", i, {hs, stall_cnt}, {1'b1, d[i], 1'b1, 2'd1, 16'd0});
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (actv !== exp_all()) begin
      errors++;
      $display("[TB] FAIL stream_end: got %h expected %h", actv, exp_all());
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] a, b, c;
    a = {$urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom};
    out_ready = 1'b0; in_valid = 1'b1; in_data = a;
    tick();
    in_data = b;
    tick();
    vectors++;
    if (hs !== {1'b1, a, 1'b0, 2'd2}) begin
      errors++;
      $display("[TB] FAIL bp_full: got %h expected %h", hs, {1'b1, a, 1'b0, 2'd2});
    end
    in_data = c;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if ({hs, stall_cnt} !== {1'b1, a, 1'b0, 2'd2, 16'(k)}) begin
        errors++;
        $display("[TB] FAIL bp_stall_%0d: got %h expected %h", k, {hs, stall_cnt}, {1'b1, a, 1'b0, 2'd2, 16'(k)});
      end
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if ({hs, stall_cnt} !== {1'b1, b, 1'b1, 2'd1, 16'd4}) begin
      errors++;
      $display("[TB] FAIL bp_pop_a: got %h expected %h", {hs, stall_cnt}, {1'b1, b, 1'b1, 2'd1, 16'd4});
    end
    tick();
    in_valid = 1'b0;
    vectors++;
    if ({hs, stall_cnt} !== {1'b1, c, 1'b1, 2'd1, 16'd4}) begin
      errors++;
      $display("[TB] FAIL bp_pop_b: got %h expected %h", {hs, stall_cnt}, {1'b1, c, 1'b1, 2'd1, 16'd4});
    end
    tick();
    vectors++;
    if (actv !== exp_all()) begin
      errors++;
      $display("[TB] FAIL bp_drain: got %h expected %h", actv, exp_all());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = {$urandom, $urandom, $urandom};
    tick();
    in_data = {$urandom, $urandom, $urandom};
    tick();
    flush = 1'b1; in_data = {$urandom, $urandom, $urandom};
    tick();
    flush = 1'b0; in_valid = 1'b0;
    vectors++;
    if (hs !== {1'b0, {PW{1'b0}}, 1'b1, 2'd0}) begin
      errors++;
      $display("[TB] FAIL flush_empty: got %h expected %h", hs, {1'b0, {PW{1'b0}}, 1'b1, 2'd0});
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (actv !== exp_all() || out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_after_%0d: got %h expected %h", k, actv, exp_all());
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = {$urandom, $urandom, $urandom};
    tick();
    in_data = {$urandom, $urandom, $urandom};
    tick();
    in_data = {$urandom, $urandom, $urandom};
    #3;
    rst_n = 1'b0;
    q.delete(); cnt16 = 0; cnt4 = 0;
    #1;
    vectors++;
    if (actv !== {1'b0, {PW{1'b0}}, 1'b1, 2'd0, 16'd0, 4'd0}) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected %h", actv, {1'b0, {PW{1'b0}}, 1'b1, 2'd0, 16'd0, 4'd0});
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    test_single("post_reset");
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (2) begin
      in_data = {$urandom, $urandom, $urandom};
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (actv !== exp_all()) begin
        errors++;
        $display("[TB] FAIL sat_cycle_%0d: got %h expected %h", k, actv, exp_all());
      end
    end
    vectors++;
    if ({stall_cnt4, stall_cnt} !== {4'd15, 16'd20}) begin
      errors++;
      $display("[TB] FAIL sat_final: got %h expected %h", {stall_cnt4, stall_cnt}, {4'd15, 16'd20});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = {$urandom, $urandom, $urandom};
      tick();
      vectors++;
      if (actv !== exp_all() || hs4 !== exp_hs()) begin
        errors++;
        $display("[TB] FAIL random_%0d: got %h/%h expected %h", i, actv, hs4, exp_all());
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised, elastic successor to the fixed IF/ID pipeline register. It carries NUM_FIELDS payload fields of DATA_WIDTH bits each, for example instr/PC/PCPlus4. Plain enable/flush control is replaced by a valid/ready handshake on both sides, backed by a 2-entry (main + skid) buffer, so back-pressure never creates a combinational ready path. It sits between any two pipeline stages (F→D, D→E, …) and drives bubbles as all-zero payload.

Parameters:
DATA_WIDTH, 32, width of one payload field
NUM_FIELDS, 3, number of fields concatenated into the payload (field 0 in the LSBs)
CNT_WIDTH, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all buffered entries
in_valid  input  1  upstream has a payload
in_ready  output  1  stage can accept a payload
in_data  input  NUM_FIELDS*DATA_WIDTH  upstream payload
out_valid  output  1  stage presents a payload
out_ready  input  1  downstream accepts the payload
out_data  output  NUM_FIELDS*DATA_WIDTH  presented payload, zero when out_valid=0
occupancy  output  2  entries held (0..2)
stall_cnt  output  CNT_WIDTH  cycles with in_valid=1 and in_ready=0, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n), fixed as decided.
- Reset values while rst_n=0 and immediately after release:
  - main and skid entries invalid, data registers 0, state EMPTY
  - out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0
  - No push is recorded while rst_n=0.
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !skid_valid, driven from a register only. It has no combinational dependence on out_ready or in_valid.
- out_valid = main_valid. out_data = main_data masked to 0 when main_valid=0.
- State is encoded by occupancy: EMPTY (0), ONE (1), FULL (2). Transitions, where flush=0:
  - EMPTY: push → ONE, main<=in_data. Pop is impossible.
  - ONE, push & pop → ONE, main<=in_data.
  - ONE, push & !pop → FULL, skid<=in_data, main held.
  - ONE, !push & pop → EMPTY.
  - ONE, idle → ONE, main held.
  - FULL: in_ready=0 so no push. Pop → ONE, main<=skid, skid invalidated. Otherwise hold.
- Ordering is strict FIFO. The main entry is always older than the skid entry.
- Latency: 1 cycle from push to out_valid when the stage is EMPTY. Throughput is 1 per cycle with out_ready held high.
- Payload is held stable while out_valid=1 and out_ready=0.
- flush (synchronous, highest priority):
  - Next state is EMPTY; both entries are invalidated and their data registers zeroed.
  - A push in the flush cycle is consumed and discarded; in_ready keeps its normal value.
  - A pop in the flush cycle completes normally downstream.
  - stall_cnt is unaffected by flush.
- stall_cnt increments by 1 on every cycle with in_valid=1 & in_ready=0, including flush cycles. It saturates at 2^CNT_WIDTH-1 and clears only on reset.
- Reset asserted mid-operation clears everything immediately, without waiting for clk. Buffered payloads are lost.
- Width rule: field k occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH] of in_data and out_data.

Test Plan:
1. Reset, then a single push of {PCPlus4=0x104, PC=0x100, instr=0x00500093} with out_ready=1:
   - out_valid=1 with identical out_data on the next cycle
   - occupancy 0→1→0; in_ready stays 1
2. Streaming: 8 back-to-back pushes with out_ready=1:
   - one output per cycle, order preserved
   - occupancy stays 1, stall_cnt=0
3. Back-pressure: out_ready=0 and pushes A, B, C offered:
   - A and B accepted; occupancy=2; in_ready=0
   - C held; stall_cnt increments each cycle
   - out_ready=1 then pops A, B, C in order; out_data stays A while stalled
4. flush while FULL (A, B buffered) with push of C in the same cycle:
   - next cycle occupancy=0, out_valid=0, out_data=0
   - C never appears at the output
5. Async reset mid-stream: drop rst_n between clock edges while occupancy=2:
   - outputs go to reset values before the next edge
   - after release, a new push behaves as in scenario 1
6. Saturation with CNT_WIDTH=4: hold in_valid=1 with the stage FULL for 20 cycles:
   - stall_cnt reaches 15 and stays at 15
